alu_op_sequencer: RTL and testbench

- Issue-side controller for the 8-bit shifter/ALU datapath: accepts encoded instructions over a valid/ready handshake, reads operands from a 4x8 register file, drives the shifter/ALU input bundle, captures the result, writes it back and returns it over a valid/ready result channel.
- The shifter/ALU remains a separate combinational instance; this block owns all sequencing and state around it.

---
 rtl/alu_op_sequencer_pkg.sv | 64 ++++++
 rtl/alu_op_regfile.sv | 51 +++++
 rtl/alu_op_sequencer.sv | 140 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: instruction layout,
// FSM state encoding and operation codes understood by the shifter/ALU.
package alu_op_sequencer_pkg;

  localparam int DATA_W  = 8;
  localparam int NREGS   = 4;
  localparam int ADDR_W  = 2;
  localparam int INSTR_W = 16;

  // Instruction field bit positions
  localparam int OPER_HI     = 15;
  localparam int OPER_LO     = 13;
  localparam int SEL_OUT_BIT = 12;
  localparam int SEL_AMT_BIT = 11;
  localparam int IMM_HI      = 10;
  localparam int IMM_LO      = 8;
  localparam int RD_HI       = 7;
  localparam int RD_LO       = 6;
  localparam int RS1_HI      = 5;
  localparam int RS1_LO      = 4;
  localparam int RS2_HI      = 3;
  localparam int RS2_LO      = 2;
  localparam int RSV_HI      = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Operation codes; 6 and 7 are passed through untouched.
  typedef enum logic [2:0] {
    OPER_PASS = 3'd0,
    OPER_ADD  = 3'd1,
    OPER_SUB  = 3'd2,
    OPER_AND  = 3'd3,
    OPER_OR   = 3'd4,
    OPER_NOT  = 3'd5
  } oper_e;

  typedef struct packed {
    logic [2:0]        oper;
    logic              sel_out;
    logic              sel_shift_amt;
    logic [2:0]        shift_imm;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
  } instr_t;

  // Split the meaningful upper bits of an instruction word into fields.
  function automatic instr_t decode_instr(input logic [INSTR_W-1:RSV_HI+1] word);
    instr_t f;
    f.oper          = word[OPER_HI:OPER_LO];
    f.sel_out       = word[SEL_OUT_BIT];
    f.sel_shift_amt = word[SEL_AMT_BIT];
    f.shift_imm     = word[IMM_HI:IMM_LO];
    f.rd            = word[RD_HI:RD_LO];
    f.rs1           = word[RS1_HI:RS1_LO];
    f.rs2           = word[RS2_HI:RS2_LO];
    return f;
  endfunction

endpackage

// File: rtl/alu_op_regfile.sv
// 4x8 operand register file: two asynchronous read ports, a writeback port
// that beats the external preload port when both target the same entry,
// and an asynchronous clear.
module alu_op_regfile
  import alu_op_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              pl_en,
  input  logic [ADDR_W-1:0] pl_addr,
  input  logic [DATA_W-1:0] pl_data
);

  logic [NREGS-1:0][DATA_W-1:0] regs_flat;

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_entry
      logic [DATA_W-1:0] entry_reg;
      logic              wb_hit;
      logic              pl_hit;

      assign wb_hit = wb_en && (wb_addr == ADDR_W'(gi));
      assign pl_hit = pl_en && (pl_addr == ADDR_W'(gi));

      // One entry: writeback has priority, preload only when writeback misses
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_reg <= '0;
        end else if (wb_hit) begin
          entry_reg <= wb_data;
        end else if (pl_hit) begin
          entry_reg <= pl_data;
        end
      end

      assign regs_flat[gi] = entry_reg;
    end
  endgenerate

  // Reads see the pre-edge contents, so a same-cycle preload is not bypassed
  assign rd_data1 = regs_flat[rd_addr1];
  assign rd_data2 = regs_flat[rd_addr2];

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue-side controller around the combinational shifter/ALU: accepts an
// instruction, presents operands for one EXEC cycle, captures and writes
// back the result, then holds it on the result channel until taken.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  output logic [DATA_W-1:0]  alu_inp1,
  output logic [DATA_W-1:0]  alu_inp2,
  output logic [2:0]         alu_shiftImm,
  output logic               alu_selShiftAmt,
  output logic [2:0]         alu_oper,
  output logic               alu_selOut,
  input  logic [DATA_W-1:0]  alu_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [DATA_W-1:0]  res_data,
  output logic [ADDR_W-1:0]  res_rd,
  output logic [7:0]         op_count
);

  state_t            state_reg;
  logic              instr_ready_reg;
  logic              res_valid_reg;
  logic [DATA_W-1:0] inp1_reg;
  logic [DATA_W-1:0] inp2_reg;
  logic [2:0]        shift_imm_reg;
  logic              sel_shift_amt_reg;
  logic [2:0]        oper_reg;
  logic              sel_out_reg;
  logic [ADDR_W-1:0] rd_reg;
  logic [DATA_W-1:0] res_data_reg;
  logic [ADDR_W-1:0] res_rd_reg;
  logic [7:0]        op_count_reg;

  instr_t            fields;
  logic [DATA_W-1:0] rf_data1;
  logic [DATA_W-1:0] rf_data2;
  logic              accept;
  logic              wb_en;
  logic              unused_rsv;

  assign fields     = decode_instr(instr[INSTR_W-1:RSV_HI+1]);
  assign unused_rsv = ^instr[RSV_HI:0];
  assign accept     = (state_reg == ST_IDLE) && instr_valid && instr_ready_reg;
  // Writeback happens on the edge that closes EXEC
  assign wb_en      = (state_reg == ST_EXEC);

  alu_op_regfile u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr1 (fields.rs1),
    .rd_addr2 (fields.rs2),
    .rd_data1 (rf_data1),
    .rd_data2 (rf_data2),
    .wb_en    (wb_en),
    .wb_addr  (rd_reg),
    .wb_data  (alu_out),
    .pl_en    (wr_en),
    .pl_addr  (wr_addr),
    .pl_data  (wr_data)
  );

  // Sequencing FSM with all handshake and datapath outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= ST_IDLE;
      instr_ready_reg   <= 1'b0;
      res_valid_reg     <= 1'b0;
      inp1_reg          <= '0;
      inp2_reg          <= '0;
      shift_imm_reg     <= '0;
      sel_shift_amt_reg <= 1'b0;
      oper_reg          <= '0;
      sel_out_reg       <= 1'b0;
      rd_reg            <= '0;
      res_data_reg      <= '0;
      res_rd_reg        <= '0;
      op_count_reg      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            inp1_reg          <= rf_data1;
            inp2_reg          <= rf_data2;
            shift_imm_reg     <= fields.shift_imm;
            sel_shift_amt_reg <= fields.sel_shift_amt;
            oper_reg          <= fields.oper;
            sel_out_reg       <= fields.sel_out;
            rd_reg            <= fields.rd;
            instr_ready_reg   <= 1'b0;
            state_reg         <= ST_EXEC;
          end else begin
            // First cycle out of reset lands here with ready still low
            instr_ready_reg <= 1'b1;
          end
        end
        ST_EXEC: begin
          res_data_reg  <= alu_out;
          res_rd_reg    <= rd_reg;
          op_count_reg  <= op_count_reg + 8'd1;
          res_valid_reg <= 1'b1;
          state_reg     <= ST_RESP;
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid_reg   <= 1'b0;
            instr_ready_reg <= 1'b1;
            state_reg       <= ST_IDLE;
          end
        end
        default: begin
          res_valid_reg   <= 1'b0;
          instr_ready_reg <= 1'b0;
          state_reg       <= ST_IDLE;
        end
      endcase
    end
  end

  assign instr_ready     = instr_ready_reg;
  assign res_valid       = res_valid_reg;
  assign res_data        = res_data_reg;
  assign res_rd          = res_rd_reg;
  assign op_count        = op_count_reg;
  assign alu_inp1        = inp1_reg;
  assign alu_inp2        = inp2_reg;
  assign alu_shiftImm    = shift_imm_reg;
  assign alu_selShiftAmt = sel_shift_amt_reg;
  assign alu_oper        = oper_reg;
  assign alu_selOut      = sel_out_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural shifter/ALU drives alu_out, and a
// register/counter model predicts every observable result.
module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [7:0]  alu_inp1;
  logic [7:0]  alu_inp2;
  logic [2:0]  alu_shiftImm;
  logic        alu_selShiftAmt;
  logic [2:0]  alu_oper;
  logic        alu_selOut;
  logic [7:0]  alu_out;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;
  logic [1:0]  res_rd;
  logic [7:0]  op_count;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] rf_model [4];
  int         op_count_model = 0;
  int         n_ops = 0;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .alu_inp1        (alu_inp1),
    .alu_inp2        (alu_inp2),
    .alu_shiftImm    (alu_shiftImm),
    .alu_selShiftAmt (alu_selShiftAmt),
    .alu_oper        (alu_oper),
    .alu_selOut      (alu_selOut),
    .alu_out         (alu_out),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_data        (res_data),
    .res_rd          (res_rd),
    .op_count        (op_count)
  );

  // Behaviour of the attached shifter/ALU: right shift by the immediate or
  // by inp2[2:0]; arithmetic wraps mod 256; codes 6/7 give inp1 ^ inp2.
  function automatic logic [7:0] alu_fn(input logic [2:0] oper, input logic sel_out,
                                        input logic sel_amt, input logic [2:0] imm,
                                        input logic [7:0] a, input logic [7:0] b);
    int amt;
    amt = sel_amt ? int'(imm) : int'(b[2:0]);
    if (sel_out) return 8'((int'(a)) >> amt);
    case (oper)
      3'd0:    return a;
      3'd1:    return 8'((int'(a) + int'(b)) % 256);
      3'd2:    return 8'((int'(a) - int'(b) + 256) % 256);
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return ~a;
      default: return a ^ b;
    endcase
  endfunction

  always_comb alu_out = alu_fn(alu_oper, alu_selOut, alu_selShiftAmt, alu_shiftImm,
                               alu_inp1, alu_inp2);

  function automatic logic [15:0] mk_instr(input logic [2:0] oper, input logic sel_out,
                                           input logic sel_amt, input logic [2:0] imm,
                                           input logic [1:0] rd, input logic [1:0] rs1,
                                           input logic [1:0] rs2, input logic [1:0] rsv);
    return {oper, sel_out, sel_amt, imm, rd, rs1, rs2, rsv};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".instr_ready"}, 32'(instr_ready), 0);
    check({tag, ".res_valid"}, 32'(res_valid), 0);
    check({tag, ".res_data"}, 32'(res_data), 0);
    check({tag, ".res_rd"}, 32'(res_rd), 0);
    check({tag, ".op_count"}, 32'(op_count), 0);
    check({tag, ".alu_bundle"},
          32'({alu_inp1, alu_inp2, alu_shiftImm, alu_selShiftAmt, alu_oper, alu_selOut}), 0);
  endtask

  task automatic preload(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    rf_model[a] = d;
  endtask

  // One full instruction. pl_when: 0 none, 1 preload on the accept edge,
  // 2 preload on the EXEC edge. hold: RESP cycles with res_ready low.
  task automatic run_op(input string name, input logic [2:0] oper, input logic sel_out,
                        input logic sel_amt, input logic [2:0] imm, input logic [1:0] rd,
                        input logic [1:0] rs1, input logic [1:0] rs2, input int pl_when,
                        input logic [1:0] pl_addr, input logic [7:0] pl_data, input int hold);
    logic [7:0] a, b, exp;
    a   = rf_model[rs1];
    b   = rf_model[rs2];
    exp = alu_fn(oper, sel_out, sel_amt, imm, a, b);
    @(negedge clk);
    check({name, ".ready_idle"}, 32'(instr_ready), 1);
    instr_valid = 1'b1;
    instr       = mk_instr(oper, sel_out, sel_amt, imm, rd, rs1, rs2, 2'($urandom));
    res_ready   = (hold == 0);
    if (pl_when == 1) begin
      wr_en = 1'b1; wr_addr = pl_addr; wr_data = pl_data;
    end
    @(posedge clk); #1;
    if (pl_when == 1) rf_model[pl_addr] = pl_data;
    check({name, ".inp1"}, 32'(alu_inp1), 32'(a));
    check({name, ".inp2"}, 32'(alu_inp2), 32'(b));
    check({name, ".ctrl"}, 32'({alu_oper, alu_selOut, alu_selShiftAmt, alu_shiftImm}),
          32'({oper, sel_out, sel_amt, imm}));
    check({name, ".ready_exec"}, 32'(instr_ready), 0);
    check({name, ".valid_exec"}, 32'(res_valid), 0);
    @(negedge clk);
    instr_valid = (hold > 0);
    instr       = 16'($urandom);
    wr_en       = (pl_when == 2);
    if (pl_when == 2) begin
      wr_addr = pl_addr; wr_data = pl_data;
    end
    @(posedge clk); #1;
    rf_model[rd] = exp;
    if (pl_when == 2 && pl_addr != rd) rf_model[pl_addr] = pl_data;
    op_count_model = (op_count_model + 1) % 256;
    check({name, ".res_valid"}, 32'(res_valid), 1);
    check({name, ".res_data"}, 32'(res_data), 32'(exp));
    check({name, ".res_rd"}, 32'(res_rd), 32'(rd));
    check({name, ".op_count"}, 32'(op_count), 32'(op_count_model));
    check({name, ".inp1_held"}, 32'(alu_inp1), 32'(a));
    @(negedge clk);
    wr_en = 1'b0;
    for (int i = 0; i < hold; i++) begin
      instr_valid = ~instr_valid;
      @(posedge clk); #1;
      check({name, ".bp_valid"}, 32'(res_valid), 1);
      check({name, ".bp_data"}, 32'(res_data), 32'(exp));
      check({name, ".bp_ready"}, 32'(instr_ready), 0);
      check({name, ".bp_count"}, 32'(op_count), 32'(op_count_model));
      check({name, ".bp_inp1"}, 32'(alu_inp1), 32'(a));
      @(negedge clk);
    end
    res_ready   = 1'b1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    check({name, ".valid_done"}, 32'(res_valid), 0);
    check({name, ".ready_done"}, 32'(instr_ready), 1);
    check({name, ".count_done"}, 32'(op_count), 32'(op_count_model));
    n_ops++;
    $display("op %0d %s: oper=%0d selOut=%0d rd=%0d rs1=%0d rs2=%0d a=%0d b=%0d res=%0d count=%0d",
             n_ops, name, oper, sel_out, rd, rs1, rs2, a, b, res_data, op_count);
  endtask

  // Observe a register through a PASS op that writes the value back to itself
  task automatic read_reg(input string name, input logic [1:0] r, input logic [7:0] exp);
    check({name, ".model"}, 32'(rf_model[r]), 32'(exp));
    run_op(name, 3'd0, 1'b0, 1'b0, 3'd0, r, r, 2'd0, 0, 2'd0, 8'd0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0; res_ready = 1'b1;
    for (int i = 0; i < 4; i++) rf_model[i] = 8'd0;

    // Reset state
    #12;
    check_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", 32'(instr_ready), 1);

    // Basic ADD with 2-edge latency
    preload(2'd1, 8'd80);
    preload(2'd2, 8'd20);
    run_op("add", 3'd1, 1'b0, 1'b0, 3'd0, 2'd3, 2'd1, 2'd2, 0, 2'd0, 8'd0, 0);
    check("add_count_one", 32'(op_count), 1);
    read_reg("rd_r3", 2'd3, 8'd100);

    // Shifter path with immediate shift amount
    run_op("shift", 3'd1, 1'b1, 1'b1, 3'd2, 2'd0, 2'd1, 2'd2, 0, 2'd0, 8'd0, 0);
    check("shift_value", 32'(res_data), 20);

    // ADD overflow wraps
    preload(2'd1, 8'd150);
    preload(2'd2, 8'd150);
    run_op("ovf", 3'd1, 1'b0, 1'b0, 3'd0, 2'd3, 2'd1, 2'd2, 0, 2'd0, 8'd0, 0);
    check("ovf_value", 32'(res_data), 44);

    // Backpressure for 5 cycles with instr_valid pulsing
    run_op("bp", 3'd4, 1'b0, 1'b0, 3'd0, 2'd0, 2'd1, 2'd3, 0, 2'd0, 8'd0, 5);

    // Writeback wins a same-address preload; different addresses both land
    preload(2'd1, 8'd80);
    preload(2'd2, 8'd20);
    run_op("coll_same", 3'd1, 1'b0, 1'b0, 3'd0, 2'd3, 2'd1, 2'd2, 2, 2'd3, 8'hAA, 0);
    read_reg("coll_same_r3", 2'd3, 8'd100);
    run_op("coll_diff", 3'd1, 1'b0, 1'b0, 3'd0, 2'd3, 2'd1, 2'd2, 2, 2'd0, 8'hAA, 0);
    read_reg("coll_diff_r0", 2'd0, 8'hAA);
    read_reg("coll_diff_r3", 2'd3, 8'd100);

    // Operand read on the accept edge sees the pre-preload value
    run_op("rdpl", 3'd2, 1'b0, 1'b0, 3'd0, 2'd0, 2'd1, 2'd2, 1, 2'd1, 8'd15, 0);
    check("rdpl_value", 32'(res_data), 60);
    read_reg("rdpl_r1", 2'd1, 8'd15);

    // Randomized operations with random preload timing
    for (int k = 0; k < 24; k++) begin
      run_op("rand", 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
             3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
             int'($urandom_range(0, 2)), 2'($urandom), 8'($urandom),
             int'($urandom_range(0, 2)));
    end

    // Asynchronous reset in the middle of EXEC
    @(negedge clk);
    instr_valid = 1'b1;
    instr = mk_instr(3'd1, 1'b0, 1'b0, 3'd0, 2'd1, 2'd1, 2'd1, 2'd0);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("rst_exec_accepted", 32'(alu_oper), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_exec");
    for (int i = 0; i < 4; i++) rf_model[i] = 8'd0;
    op_count_model = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_exec_ready", 32'(instr_ready), 1);

    // 256 back-to-back ops (first one reads back r1) -> counter wraps to 0
    read_reg("rst_r1", 2'd1, 8'd0);
    for (int k = 1; k < 256; k++) begin
      run_op("b2b", 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
             3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 0, 2'd0, 8'd0, 0);
    end
    check("wrap_count", 32'(op_count), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
